// File: rtl/jstk_poll_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : jstk_poll_scheduler
//  Purpose  : Round-robin poll sequencer for two PmodJSTK SPI engines
//             (A = left paddle, B = right paddle). Pulses sndRec per engine,
//             waits out the SPI transfer, then latches and decodes DOUT into
//             X/Y/button registers with a one-cycle valid strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module jstk_poll_scheduler #(
  parameter int POLL_PERIOD   = 250000,
  parameter int SNDREC_CYCLES = 16,
  parameter int XFER_CYCLES   = 20000,
  parameter int CNT_W         = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  led_a,
  input  logic [1:0]  led_b,
  input  logic [39:0] jstk_data_a,
  input  logic [39:0] jstk_data_b,
  output logic        sndRec_a,
  output logic        sndRec_b,
  output logic [7:0]  sndData_a,
  output logic [7:0]  sndData_b,
  output logic [9:0]  x_a,
  output logic [9:0]  y_a,
  output logic [9:0]  x_b,
  output logic [9:0]  y_b,
  output logic [2:0]  btn_a,
  output logic [2:0]  btn_b,
  output logic        valid_a,
  output logic        valid_b,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND_A  = 3'd1,
    S_WAIT_A  = 3'd2,
    S_LATCH_A = 3'd3,
    S_SEND_B  = 3'd4,
    S_WAIT_B  = 3'd5,
    S_LATCH_B = 3'd6
  } state_t;

  // Terminal counts: every timed phase compares against limit-1 and then
  // clears, so the timer never wraps.
  localparam logic [CNT_W-1:0] c_poll_last = CNT_W'(POLL_PERIOD - 1);
  localparam logic [CNT_W-1:0] c_snd_last  = CNT_W'(SNDREC_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_xfer_last = CNT_W'(XFER_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_zero      = '0;
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
  localparam logic [9:0]       c_center    = 10'd512;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             sndrec_a_q, sndrec_a_d;
  logic             sndrec_b_q, sndrec_b_d;
  logic             valid_a_q, valid_a_d;
  logic             valid_b_q, valid_b_d;
  logic             busy_q, busy_d;
  logic [9:0]       x_a_q, x_a_d, y_a_q, y_a_d;
  logic [9:0]       x_b_q, x_b_d, y_b_q, y_b_d;
  logic [2:0]       btn_a_q, btn_a_d, btn_b_q, btn_b_d;

  // PmodJSTK DOUT layout: X high bits live in byte 3, Y high bits in byte 1.
  function automatic logic [9:0] f_dec_x(input logic [39:0] d);
    return {d[25:24], d[39:32]};
  endfunction

  function automatic logic [9:0] f_dec_y(input logic [39:0] d);
    return {d[9:8], d[23:16]};
  endfunction

  // Bits of DOUT that carry no information for the game logic.
  logic w_unused_bits;
  assign w_unused_bits = ^{jstk_data_a[31:26], jstk_data_a[15:10], jstk_data_a[7:3],
                           jstk_data_b[31:26], jstk_data_b[15:10], jstk_data_b[7:3]};

  // Next-state, timer and capture logic for the poll sequence.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    x_a_d     = x_a_q;
    y_a_d     = y_a_q;
    btn_a_d   = btn_a_q;
    x_b_d     = x_b_q;
    y_b_d     = y_b_q;
    btn_b_d   = btn_b_q;
    valid_a_d = 1'b0;
    valid_b_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Timer only advances while enabled; a paused count resumes later.
        if (enable) begin
          if (timer_q == c_poll_last) begin
            state_d = S_SEND_A;
            timer_d = c_zero;
          end else begin
            timer_d = timer_q + c_one;
          end
        end
      end
      S_SEND_A: begin
        if (timer_q == c_snd_last) begin
          state_d = S_WAIT_A;
          timer_d = c_zero;
        end else begin
          timer_d = timer_q + c_one;
        end
      end
      S_WAIT_A: begin
        if (timer_q == c_xfer_last) begin
          state_d = S_LATCH_A;
          timer_d = c_zero;
        end else begin
          timer_d = timer_q + c_one;
        end
      end
      S_LATCH_A: begin
        x_a_d     = f_dec_x(jstk_data_a);
        y_a_d     = f_dec_y(jstk_data_a);
        btn_a_d   = jstk_data_a[2:0];
        valid_a_d = 1'b1;
        state_d   = S_SEND_B;
        timer_d   = c_zero;
      end
      S_SEND_B: begin
        if (timer_q == c_snd_last) begin
          state_d = S_WAIT_B;
          timer_d = c_zero;
        end else begin
          timer_d = timer_q + c_one;
        end
      end
      S_WAIT_B: begin
        if (timer_q == c_xfer_last) begin
          state_d = S_LATCH_B;
          timer_d = c_zero;
        end else begin
          timer_d = timer_q + c_one;
        end
      end
      S_LATCH_B: begin
        x_b_d     = f_dec_x(jstk_data_b);
        y_b_d     = f_dec_y(jstk_data_b);
        btn_b_d   = jstk_data_b[2:0];
        valid_b_d = 1'b1;
        state_d   = S_IDLE;
        timer_d   = c_zero;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = c_zero;
      end
    endcase

    // Request lines and busy are registered copies of the upcoming state,
    // so they line up exactly with the state they describe.
    sndrec_a_d = (state_d == S_SEND_A);
    sndrec_b_d = (state_d == S_SEND_B);
    busy_d     = (state_d != S_IDLE);
  end

  // State, timer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= c_zero;
      sndrec_a_q <= 1'b0;
      sndrec_b_q <= 1'b0;
      valid_a_q  <= 1'b0;
      valid_b_q  <= 1'b0;
      busy_q     <= 1'b0;
      x_a_q      <= c_center;
      y_a_q      <= c_center;
      x_b_q      <= c_center;
      y_b_q      <= c_center;
      btn_a_q    <= 3'd0;
      btn_b_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sndrec_a_q <= sndrec_a_d;
      sndrec_b_q <= sndrec_b_d;
      valid_a_q  <= valid_a_d;
      valid_b_q  <= valid_b_d;
      busy_q     <= busy_d;
      x_a_q      <= x_a_d;
      y_a_q      <= y_a_d;
      x_b_q      <= x_b_d;
      y_b_q      <= y_b_d;
      btn_a_q    <= btn_a_d;
      btn_b_q    <= btn_b_d;
    end
  end

  // LED command bytes pass straight through; the engine samples them itself.
  assign sndData_a = {6'b100000, led_a};
  assign sndData_b = {6'b100000, led_b};

  assign sndRec_a = sndrec_a_q;
  assign sndRec_b = sndrec_b_q;
  assign valid_a  = valid_a_q;
  assign valid_b  = valid_b_q;
  assign busy     = busy_q;
  assign x_a      = x_a_q;
  assign y_a      = y_a_q;
  assign btn_a    = btn_a_q;
  assign x_b      = x_b_q;
  assign y_b      = y_b_q;
  assign btn_b    = btn_b_q;

endmodule
`default_nettype wire

// File: tb/tb_jstk_poll_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jstk_poll_scheduler
//  Purpose  : Self-checking bench for jstk_poll_scheduler. A cycle-position
//             model of the poll pair is compared against the DUT every cycle,
//             plus directed literal checks of timing, decode and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jstk_poll_scheduler;

  localparam int PP = 10;
  localparam int SR = 2;
  localparam int XF = 5;
  localparam int CW = 8;
  // Pair position (edges since IDLE exit) at which A is captured, and at
  // which B is captured and the pair ends.
  localparam int K_LATCH_A = SR + XF + 1;
  localparam int K_END     = 2 * (SR + XF + 1);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  led_a = 2'b00, led_b = 2'b00;
  logic [39:0] da = '0, db = '0;
  logic        sndRec_a, sndRec_b, valid_a, valid_b, busy;
  logic [7:0]  sndData_a, sndData_b;
  logic [9:0]  x_a, y_a, x_b, y_b;
  logic [2:0]  btn_a, btn_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jstk_poll_scheduler #(
    .POLL_PERIOD(PP), .SNDREC_CYCLES(SR), .XFER_CYCLES(XF), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .led_a(led_a), .led_b(led_b),
    .jstk_data_a(da), .jstk_data_b(db),
    .sndRec_a(sndRec_a), .sndRec_b(sndRec_b),
    .sndData_a(sndData_a), .sndData_b(sndData_b),
    .x_a(x_a), .y_a(y_a), .x_b(x_b), .y_b(y_b),
    .btn_a(btn_a), .btn_b(btn_b),
    .valid_a(valid_a), .valid_b(valid_b), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_known = 1'b0;
  bit         m_pair  = 1'b0;
  int         m_k     = 0;
  int         m_idle  = 0;
  logic [9:0] mxa = 10'd512, mya = 10'd512, mxb = 10'd512, myb = 10'd512;
  logic [2:0] mba = 3'd0, mbb = 3'd0;
  bit         mva = 1'b0, mvb = 1'b0;

  // Advance the model on each edge, then compare a moment later.
  always @(posedge clk) begin
    if (reset) begin
      m_known = 1'b1; m_pair = 1'b0; m_k = 0; m_idle = 0;
      mxa = 10'd512; mya = 10'd512; mxb = 10'd512; myb = 10'd512;
      mba = 3'd0; mbb = 3'd0; mva = 1'b0; mvb = 1'b0;
    end else if (m_known) begin
      mva = 1'b0; mvb = 1'b0;
      if (!m_pair) begin
        if (enable) begin
          if (m_idle == PP - 1) begin
            m_pair = 1'b1; m_k = 0; m_idle = 0;
          end else begin
            m_idle++;
          end
        end
      end else begin
        m_k++;
        if (m_k == K_LATCH_A) begin
          mxa = {da[25:24], da[39:32]}; mya = {da[9:8], da[23:16]}; mba = da[2:0]; mva = 1'b1;
        end
        if (m_k == K_END) begin
          mxb = {db[25:24], db[39:32]}; myb = {db[9:8], db[23:16]}; mbb = db[2:0]; mvb = 1'b1;
          m_pair = 1'b0; m_idle = 0;
        end
      end
    end
    #1;
    if (m_known) begin
      chk("sndRec_a", sndRec_a, m_pair && (m_k < SR));
      chk("sndRec_b", sndRec_b, m_pair && (m_k >= K_LATCH_A) && (m_k < K_LATCH_A + SR));
      chk("busy", busy, m_pair);
      chk("valid_a", valid_a, mva);
      chk("valid_b", valid_b, mvb);
      chk("x_a", x_a, mxa);
      chk("y_a", y_a, mya);
      chk("btn_a", btn_a, mba);
      chk("x_b", x_b, mxb);
      chk("y_b", y_b, myb);
      chk("btn_b", btn_b, mbb);
      chk("sndData_a", sndData_a, {6'b100000, led_a});
      chk("sndData_b", sndData_b, {6'b100000, led_b});
      chk("sndRec_exclusive", sndRec_a & sndRec_b, 1'b0);
    end
  end

  // Bounded wait on a DUT output reaching a value (0=sndRec_a,1=sndRec_b,2=valid_b).
  task automatic wait_for(input int sel, input logic val, input int limit, input string name);
    logic cur;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      cur = (sel == 0) ? sndRec_a : (sel == 1) ? sndRec_b : valid_b;
      if (cur === val) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout_%s: got no event expected event within %0d cycles", name, limit);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_a, first_b, first_vb, quiet;
    logic [63:0] r64;
    first_a = -1; first_b = -1; first_vb = -1;

    reset  = 1'b1;
    enable = 1'b1;
    led_a  = 2'b11;
    led_b  = 2'b01;
    da     = 40'h23_01_C1_01_05;
    db     = 40'hAB_02_7F_03_06;
    repeat (3) @(negedge clk);

    // Reset state and LED command bytes.
    chk("rst_x_a", x_a, 10'd512);
    chk("rst_y_b", y_b, 10'd512);
    chk("rst_btn_a", btn_a, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sndRec_a", sndRec_a, 1'b0);
    chk("rst_valid_b", valid_b, 1'b0);
    chk("led_sndData_a", sndData_a, 8'h83);
    chk("led_sndData_b", sndData_b, 8'h81);

    // Two full pairs from reset release, with literal timing and decode pins.
    reset = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (sndRec_a && first_a < 0) first_a = i;
      if (sndRec_b && first_b < 0) first_b = i;
      if (valid_b && first_vb < 0) first_vb = i;
      if (i == 18) begin
        chk("dec_x_a", x_a, 10'h123);
        chk("dec_y_a", y_a, 10'h1C1);
        chk("dec_btn_a", btn_a, 3'b101);
        chk("dec_valid_a", valid_a, 1'b1);
      end
      if (i == 19) chk("valid_a_one_cycle", valid_a, 1'b0);
      if (i == 26) begin
        chk("dec_x_b", x_b, 10'h2AB);
        chk("dec_y_b", y_b, 10'h37F);
        chk("dec_btn_b", btn_b, 3'b110);
      end
      if (i == 47) db = 40'h11_00_22_00_01;   // second pair, during WAIT_B
      if (i == 50) chk("hold_x_b", x_b, 10'h2AB);
      if (i == 52) begin
        chk("relatch_x_b", x_b, 10'h011);
        chk("relatch_y_b", y_b, 10'h022);
        chk("relatch_valid_b", valid_b, 1'b1);
      end
      if (i == 53) db = 40'hFF_03_FF_03_07;   // after the latch: must not show
      if (i == 60) chk("post_latch_hold_x_b", x_b, 10'h011);
    end
    chk("first_sndRec_a", first_a, 10);
    chk("first_sndRec_b", first_b, 18);
    chk("first_valid_b", first_vb, 26);

    // Drop enable during WAIT_A: pair still completes, then stays quiet.
    wait_for(0, 1'b1, 40, "sndRec_a_rise");
    wait_for(0, 1'b0, 10, "sndRec_a_fall");
    enable = 1'b0;
    wait_for(2, 1'b1, 40, "valid_b_after_disable");
    quiet = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sndRec_a || sndRec_b || busy) quiet++;
    end
    chk("disabled_quiet", quiet, 0);
    enable = 1'b1;
    wait_for(0, 1'b1, PP + 2, "resume_sndRec_a");

    // Reset during SEND_B.
    wait_for(1, 1'b1, 40, "sndRec_b_rise");
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_sndRec_b", sndRec_b, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_x_a", x_a, 10'd512);
    chk("rstmid_valid_b", valid_b, 1'b0);
    reset = 1'b0;

    // Randomized traffic: data, LEDs, enable toggles and rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r64 = {$urandom, $urandom};
      da = r64[39:0];
      r64 = {$urandom, $urandom};
      db = r64[39:0];
      led_a = 2'($urandom_range(0, 3));
      led_b = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      reset = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
